// File: rtl/afisaj_mmss.sv
// Four-digit multiplexed MM:SS seven-segment driver.
// Binary inputs are converted to decimal by repeated subtraction once per scan frame.
module afisaj_mmss #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] valoare_sec,
  input  logic [5:0] valoare_min,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  // state    | meaning
  // IDLE     | waiting for frame tick or pending start
  // CONV_SEC | subtracting tens from captured seconds
  // CONV_MIN | subtracting tens from captured minutes
  // UPDATE   | load all display digits together
  typedef enum logic [1:0] {IDLE, CONV_SEC, CONV_MIN, UPDATE} state_t;

  state_t      state, state_n;
  logic [15:0] cnt;
  logic [1:0]  idx;
  logic        digit_tick, frame_tick, start, pending;
  logic [5:0]  rem_sec, rem_min;
  logic [2:0]  tens_sec, tens_min;
  logic [3:0]  dig0, dig1, dig2, dig3, cur;

  assign digit_tick = (cnt == 16'(REFRESH_DIV - 1));
  assign frame_tick = digit_tick && (idx == 2'd3);
  assign start      = frame_tick || pending;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (digit_tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start) state_n = CONV_SEC;
      CONV_SEC: if (rem_sec < 6'd10) state_n = CONV_MIN;
      CONV_MIN: if (rem_min < 6'd10) state_n = UPDATE;
      UPDATE:   state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Digits only change in UPDATE, so the display never mixes two conversions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= 1'b1;
      rem_sec  <= '0;
      rem_min  <= '0;
      tens_sec <= '0;
      tens_min <= '0;
      dig0     <= '0;
      dig1     <= '0;
      dig2     <= '0;
      dig3     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pending  <= 1'b0;
          rem_sec  <= valoare_sec;
          rem_min  <= valoare_min;
          tens_sec <= '0;
          tens_min <= '0;
        end
        CONV_SEC: if (rem_sec >= 6'd10) begin
          rem_sec  <= rem_sec - 6'd10;
          tens_sec <= tens_sec + 3'd1;
        end
        CONV_MIN: if (rem_min >= 6'd10) begin
          rem_min  <= rem_min - 6'd10;
          tens_min <= tens_min + 3'd1;
        end
        UPDATE: begin
          dig0 <= rem_sec[3:0];
          dig1 <= {1'b0, tens_sec};
          dig2 <= rem_min[3:0];
          dig3 <= {1'b0, tens_min};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (idx)
      2'd0:    cur = dig0;
      2'd1:    cur = dig1;
      2'd2:    cur = dig2;
      default: cur = dig3;
    endcase
    case (cur)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    an = ~(4'b0001 << idx);
    if (BLANK_LZ && (idx == 2'd3) && (dig3 == 4'd0)) an = 4'b1111;
    dp = (idx != 2'd2);
  end

endmodule

// File: tb/tb_afisaj_mmss.sv
// Randomized scoreboard bench for afisaj_mmss with a cycle-count reference model.
module tb_afisaj_mmss;
  localparam int RD    = 4;
  localparam int FRAME = 4 * RD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] sec = '0, mn = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, busy;

  afisaj_mmss #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .valoare_sec(sec), .valoare_min(mn),
    .an(an), .seg(seg), .dp(dp), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [15:0] digs;
  } exp_t;

  exp_t q[$];
  int   tests = 0, errors = 0;
  int   e = 0, cap_c = 0, cap_l = 0, cap_end = 0;
  bit   checking = 1'b0;
  logic [6:0] seg_lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got 'h%0h, expected 'h%0h", name, e, act, exp);
    end
  endtask

  // Captures happen on the first edge after reset and on every frame boundary
  // (every FRAME edges) when no conversion is still running.
  task automatic model_step();
    int s, m;
    exp_t x;
    if (e == 1 || (e % FRAME == 0 && e > cap_end)) begin
      s = int'(sec);
      m = int'(mn);
      cap_c   = e;
      cap_l   = s / 10 + m / 10 + 3;
      cap_end = e + cap_l;
      x.len   = cap_l;
      x.digs  = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
      q.push_back(x);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    e++;
    model_step();
    #1;
  endtask

  task automatic do_reset(logic [5:0] s, logic [5:0] m);
    checking = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_an", int'(an), 'b1110);
    check("rst_seg", int'(seg), 'b1000000);
    check("rst_dp", int'(dp), 1);
    check("rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    sec = s;
    mn = m;
    e = 0;
    cap_c = 0;
    cap_l = 0;
    cap_end = 0;
    reset = 1'b0;
    checking = 1'b1;
  endtask

  // Monitor: pops an expectation whenever busy falls, checks the scan every cycle.
  logic [15:0] cur = '0;
  bit          prev_busy = 1'b0;
  int          blen = 0;
  always @(negedge clk) begin
    int idx;
    int d;
    logic [3:0] exp_an;
    exp_t x;
    if (!checking) begin
      q.delete();
      prev_busy = 1'b0;
      blen = 0;
      cur = '0;
    end else begin
      check("busy", int'(busy), int'(cap_l > 0 && e >= cap_c && e < cap_c + cap_l));
      if (busy) blen++;
      if (prev_busy && !busy) begin
        if (q.size() == 0) begin
          check("conv_expected", 0, 1);
        end else begin
          x = q.pop_front();
          check("busy_len", blen, x.len);
          cur = x.digs;
        end
        blen = 0;
      end
      prev_busy = busy;
      idx = (e / RD) % 4;
      d = int'(cur[idx*4 +: 4]);
      exp_an = ~(4'b0001 << idx);
      if (idx == 3 && cur[15:12] == 4'd0) exp_an = 4'b1111;
      check("an", int'(an), int'(exp_an));
      check("seg", int'(seg), int'(seg_lut[d]));
      check("dp", int'(dp), int'(idx != 2));
    end
  end

  initial begin
    #1;
    do_reset(6'd37, 6'd12);
    repeat (2) cyc();
    sec = 6'd44;
    repeat (46) cyc();
    sec = 6'd0;
    mn = 6'd5;
    repeat (32) cyc();
    sec = 6'd63;
    mn = 6'd63;
    repeat (48) cyc();
    repeat (400) begin
      cyc();
      if ($urandom_range(7) == 0) begin
        sec = 6'($urandom_range(63));
        mn  = 6'($urandom_range(63));
      end
    end
    do_reset(6'd50, 6'd40);
    repeat (8) cyc();
    do_reset(6'($urandom_range(63)), 6'($urandom_range(63)));
    repeat (200) begin
      cyc();
      if ($urandom_range(5) == 0) begin
        sec = 6'($urandom_range(63));
        mn  = 6'($urandom_range(63));
      end
    end
    check("pending_conv", int'(q.size() <= 1), 1);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/afisaj_mmss.md
AFISAJ_MMSS -- requirements
Module: afisaj_mmss

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, giving the number of clk cycles each digit is driven; legal range 4..65535.
REQ-002 The block SHALL have parameter BLANK_LZ, default 1, which enables blanking of a zero minutes-tens digit.
REQ-003 clk  input  1  system clock; the block uses one clock, and all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 valoare_sec  input  6  binary seconds value, produced by the upstream 0..59 counter.
REQ-006 valoare_min  input  6  binary minutes value, produced by the upstream 0..59 counter.
REQ-007 an  output  4  digit anodes, active-low, one-hot-low.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 dp  output  1  decimal point, active-low.
REQ-010 busy  output  1  high while a binary-to-decimal conversion is in progress.

Function
REQ-011 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; the wrap cycle is the digit tick.
REQ-012 On each digit tick, digit index SHALL advance 0->1->2->3->0.
REQ-013 Digit mapping SHALL be:
- digit 0 = seconds units;
- digit 1 = seconds tens;
- digit 2 = minutes units;
- digit 3 = minutes tens.
REQ-014 an SHALL drive bit[index] low and all other bits high.
REQ-015 When BLANK_LZ=1 and minutes tens=0, an SHALL be 4'b1111 while index=3.
REQ-016 dp SHALL be 0 while index=2 and 1 otherwise.
REQ-017 seg SHALL encode digit values 0..9 as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000 respectively.
REQ-018 an, seg and dp SHALL depend only on registered state, with no combinational path from any input.
REQ-019 A frame tick SHALL be a digit tick that occurs while index=3.
REQ-020 The conversion FSM SHALL have the states IDLE, CONV_SEC, CONV_MIN and UPDATE.
REQ-021 IDLE -> CONV_SEC SHALL occur on a frame tick or on a pending start flag; on that edge the FSM SHALL capture valoare_sec and valoare_min and clear the tens counters.
REQ-022 In CONV_SEC, each cycle where the remainder >= 10 SHALL subtract 10 from the remainder and increment the tens counter; otherwise the FSM SHALL go to CONV_MIN.
REQ-023 CONV_MIN SHALL behave the same way on the minutes value and then go to UPDATE.
REQ-024 In UPDATE, all four display digit registers SHALL load simultaneously, and the FSM SHALL return to IDLE.
REQ-025 busy SHALL be 1 in CONV_SEC, CONV_MIN and UPDATE, for exactly t_s+t_m+3 cycles, where t_s and t_m are the tens results.
REQ-026 Inputs SHALL be sampled only on the capture edge; input changes during busy SHALL have no effect until the next capture.
REQ-027 A frame tick while busy=1 SHALL be ignored.
REQ-028 Inputs 60..63 SHALL be converted arithmetically without clamping (e.g. 63 -> tens 6, units 3).
REQ-029 Display digits SHALL never show a torn state, meaning a mix of an old and a new conversion.

Reset
REQ-030 While reset=1, the block SHALL hold:
- refresh counter=0, index=0, state=IDLE;
- display digits=0, busy=0;
- an=4'b1110, seg=7'b1000000, dp=1.
REQ-031 Reset SHALL set the pending start flag, so conversion starts on the first clk edge after reset deasserts; the flag SHALL clear on that capture.
REQ-032 Reset asserted mid-conversion SHALL abort the conversion immediately and discard partial results.

Verification
REQ-033 Assert reset -> an=1110, seg=1000000, dp=1, busy=0, with no clk edge needed.
REQ-034 With REFRESH_DIV=4, sec=37, min=12, release reset -> busy high for 7 cycles; the scan then shows seg codes for 7,3,2,1 on an 1110,1101,1011,0111; dp=0 only with an=1011.
REQ-035 With BLANK_LZ=1, sec=0, min=5 -> an stays 1111 during index 3; digits 0,0,5 appear on index 0..2.
REQ-036 Change sec from 37 to 44 two cycles into busy -> the display shows 37; 44 appears only after the next frame-tick conversion.
REQ-037 Set sec=63, min=63 -> busy lasts 15 cycles; digits show 3,6,3,6.
REQ-038 Pulse reset during CONV_MIN -> outputs return to reset values at once; after release, a fresh conversion of the current inputs completes correctly.
